camera_reg_update_sequencer: RTL
================================

CAMERA_REG_UPDATE_SEQUENCER -- requirements
Module: camera_reg_update_sequencer

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: update-table slot count and staging-buffer depth, range 1..16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: register-table address width.
REQ-003 SHALL have parameter SLOT_BASE, default 238: table address of slot 0; SLOT_BASE+NUM_SLOTS-1 must be at most 2^ADDR_WIDTH-1.
REQ-004 SHALL have parameter FILL_ENTRY, default 24'h000000: entry written to unused slots.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum wait for bus_active to rise.
REQ-006 SHALL have port clk_camera, input, 1 bit: sole clock; all logic on rising edge.
REQ-007 SHALL have port sys_rst_camera_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port upd_valid, input, 1 bit: staging-push request.
REQ-009 SHALL have port upd_ready, output, 1 bit: push accepted this cycle when upd_valid is also high.
REQ-010 SHALL have port upd_reg_addr, input, 16 bits: camera register address.
REQ-011 SHALL have port upd_reg_data, input, 8 bits: camera register value.
REQ-012 SHALL have port commit, input, 1 bit: single-cycle request to apply the staged updates.
REQ-013 SHALL have port tbl_we, output, 1 bit: register-table write enable.
REQ-014 SHALL have port tbl_addr, output, ADDR_WIDTH bits: register-table address.
REQ-015 SHALL have port tbl_din, output, 24 bits: table entry {reg_addr[15:0], data[7:0]}.
REQ-016 SHALL have port init_valid, output, 1 bit: start request to the I2C register writer.
REQ-017 SHALL have port init_ready, input, 1 bit: I2C register writer accepts the start request.
REQ-018 SHALL have port bus_active, input, 1 bit: I2C transaction in progress.
REQ-019 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-020 SHALL have port done, output, 1 bit: one-cycle pulse when an update completes.
REQ-021 SHALL have port timeout_err, output, 1 bit: sticky flag for a bus_active timeout.
REQ-022 SHALL have port staged_count, output, $clog2(NUM_SLOTS+1) bits: number of entries in the staging buffer.

Function
REQ-023 SHALL implement a state machine with states IDLE, WRITE, FILL, KICK, WAIT_START and WAIT_END; all outputs come from registers or the current state only, with no combinational input-to-output path except upd_ready.
REQ-024 SHALL assert upd_ready = (state==IDLE) && (staged_count<NUM_SLOTS); each accepted push stores {upd_reg_addr, upd_reg_data} at buffer index staged_count and increments staged_count.
REQ-025 SHALL, in IDLE with commit=1 and (staged_count>0 or a push accepted the same cycle), go to WRITE next cycle; a same-cycle push is included in the update.
REQ-026 SHALL ignore commit while busy, and ignore commit when it would stage zero entries; no state change and no tbl_we result.
REQ-027 SHALL, in WRITE, hold tbl_we=1, tbl_addr=SLOT_BASE+i and tbl_din=entry[i] for i=0..staged_count-1, one slot per cycle.
REQ-028 SHALL emit the first write on the cycle after commit is sampled.
REQ-029 SHALL, after the last staged entry, go to FILL if staged_count<NUM_SLOTS, else go to KICK.
REQ-030 SHALL, in FILL, write FILL_ENTRY to each remaining slot, one per cycle, then go to KICK.
REQ-031 SHALL produce exactly NUM_SLOTS consecutive tbl_we cycles per update.
REQ-032 SHALL hold tbl_we=0 and tbl_din=0 outside WRITE and FILL, and tbl_addr=SLOT_BASE+NUM_SLOTS-1 outside those states.
REQ-033 SHALL, in KICK, hold init_valid=1 until a cycle with init_valid && init_ready, then go to WAIT_START; init_valid SHALL NOT drop before that handshake.
REQ-034 SHALL, in WAIT_START, count cycles; bus_active=1 goes to WAIT_END.
REQ-035 SHALL, when the WAIT_START count reaches TIMEOUT_CYCLES, set timeout_err, pulse done, clear staged_count and return to IDLE.
REQ-036 SHALL, in WAIT_END, wait for bus_active=0, then pulse done, clear staged_count and return to IDLE; WAIT_END has no timeout.
REQ-037 SHALL clear timeout_err only on the next accepted commit or on reset.
REQ-038 SHALL compute the slot index modulo nothing: the index never exceeds NUM_SLOTS-1, so no address wrap occurs.

Reset
REQ-039 SHALL, while sys_rst_camera_n=0, asynchronously force state=IDLE, staged_count=0, tbl_we=0, tbl_din=0, init_valid=0, done=0, timeout_err=0 and busy=0; upd_ready is 1 after reset.
REQ-040 SHALL, on reset asserted mid-update, abort immediately, discard staged entries, and leave partially written table contents unrepaired.
REQ-041 SHALL handle reset release synchronously to clk_camera; the first active edge after release sees IDLE.

Verification
REQ-042 Stage (0x3501,0x02),(0x3502,0x40), commit -> writes 238:350102, 239:350240, 240:000000, 241:000000 on 4 consecutive cycles starting at commit+1; then init handshake; done after bus_active falls.
REQ-043 Push 4 entries, attempt a 5th -> upd_ready=0 on the 5th, staged_count=4; commit -> 4 writes, no FILL cycles.
REQ-044 Push and commit in the same cycle with an empty buffer -> one staged write plus 3 fill writes.
REQ-045 init_ready held low for 10 cycles -> init_valid stays 1 throughout; commit during busy is ignored.
REQ-046 bus_active never rises, TIMEOUT_CYCLES=16 -> timeout_err=1 and done pulse 16 cycles after the handshake; next commit clears timeout_err.
REQ-047 Assert reset during the 2nd WRITE cycle -> tbl_we=0 immediately, staged_count=0, no init_valid thereafter.

Source files
------------

// File: rtl/camera_reg_update_sequencer.sv
// camera_reg_update_sequencer: stages camera register updates, rewrites the table slots on commit,
// then kicks the I2C register writer and tracks the bus transaction to completion.
module camera_reg_update_sequencer #(
    parameter int          NUM_SLOTS      = 4,
    parameter int          ADDR_WIDTH     = 8,
    parameter int          SLOT_BASE      = 238,
    parameter logic [23:0] FILL_ENTRY     = 24'h000000,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic                             clk_camera,
    input  logic                             sys_rst_camera_n,
    input  logic                             upd_valid,
    output logic                             upd_ready,
    input  logic [15:0]                      upd_reg_addr,
    input  logic [7:0]                       upd_reg_data,
    input  logic                             commit,
    output logic                             tbl_we,
    output logic [ADDR_WIDTH-1:0]            tbl_addr,
    output logic [23:0]                      tbl_din,
    output logic                             init_valid,
    input  logic                             init_ready,
    input  logic                             bus_active,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout_err,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   staged_count
);
    localparam int CW = $clog2(NUM_SLOTS + 1);
    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WRITE, FILL, KICK, WAIT_START, WAIT_END} state_t;

    state_t        state, state_d;
    logic [CW-1:0] count_d, idx, idx_d;
    logic [TW-1:0] wait_cnt, wait_cnt_d;
    logic          done_d, timeout_d;
    logic          push, go;
    logic [23:0]   entry [NUM_SLOTS];

    assign upd_ready = (state == IDLE) && (staged_count < CW'(NUM_SLOTS));
    assign push      = upd_valid && upd_ready;
    assign go        = (state == IDLE) && commit && ((staged_count != '0) || push);

    // Table outputs depend only on the current state and the slot index register.
    assign busy       = state != IDLE;
    assign tbl_we     = (state == WRITE) || (state == FILL);
    assign tbl_addr   = tbl_we ? ADDR_WIDTH'(SLOT_BASE) + ADDR_WIDTH'(idx)
                               : ADDR_WIDTH'(SLOT_BASE + NUM_SLOTS - 1);
    assign tbl_din    = (state == WRITE) ? entry[idx[IW-1:0]] :
                        (state == FILL)  ? FILL_ENTRY : '0;
    assign init_valid = state == KICK;

    always_comb begin
        state_d    = state;
        count_d    = staged_count + CW'(push);
        idx_d      = idx;
        wait_cnt_d = wait_cnt;
        done_d     = 1'b0;
        timeout_d  = timeout_err;
        case (state)
            IDLE: begin
                if (go) begin
                    state_d   = WRITE;
                    idx_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            WRITE: begin
                idx_d = idx + CW'(1);
                if (idx == staged_count - CW'(1))
                    state_d = (staged_count < CW'(NUM_SLOTS)) ? FILL : KICK;
            end
            FILL: begin
                idx_d = idx + CW'(1);
                if (idx == CW'(NUM_SLOTS - 1)) state_d = KICK;
            end
            KICK: begin
                if (init_ready) begin
                    state_d    = WAIT_START;
                    wait_cnt_d = '0;
                end
            end
            WAIT_START: begin
                if (bus_active) begin
                    state_d = WAIT_END;
                end else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    count_d   = '0;
                end else begin
                    wait_cnt_d = wait_cnt + TW'(1);
                end
            end
            WAIT_END: begin
                if (!bus_active) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_camera or negedge sys_rst_camera_n) begin
        if (!sys_rst_camera_n) begin
            state        <= IDLE;
            staged_count <= '0;
            idx          <= '0;
            wait_cnt     <= '0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_d;
            staged_count <= count_d;
            idx          <= idx_d;
            wait_cnt     <= wait_cnt_d;
            done         <= done_d;
            timeout_err  <= timeout_d;
        end
    end

    // Staging storage needs no reset: staged_count alone defines which entries are live.
    always_ff @(posedge clk_camera) begin
        if (push) entry[staged_count[IW-1:0]] <= {upd_reg_addr, upd_reg_data};
    end
endmodule
